// File: rtl/y_binarization_if.sv
// Pixel stream bundle between the YCbCr stage and the binarizer, and onward to the writer.
interface y_binarization_if;
   // Valid-only stream: ycbcr_de / bin_de mark a pixel for one clock; there is no ready, the sink takes every beat.
   logic       ycbcr_vsync;
   logic       ycbcr_hsync;
   logic       ycbcr_de;
   logic [7:0] img_y;
   logic       bin_vsync;
   logic       bin_hsync;
   logic       bin_de;
   logic       bin_bit;
   logic [15:0] bin_rgb565;
   logic [7:0] thr_out;

   modport master (
      output ycbcr_vsync, ycbcr_hsync, ycbcr_de, img_y,
      input  bin_vsync, bin_hsync, bin_de, bin_bit, bin_rgb565, thr_out
   );

   modport slave (
      input  ycbcr_vsync, ycbcr_hsync, ycbcr_de, img_y,
      output bin_vsync, bin_hsync, bin_de, bin_bit, bin_rgb565, thr_out
   );
endinterface

// File: rtl/y_binarization.sv
// Luma binarizer with a per-frame mean threshold computed by a restoring divider in vblank.
// BIN_ADAPTIVE_EN compiles in the adaptive threshold; otherwise thr_q is the constant THR_FIXED.
module y_binarization #(
   parameter logic [7:0] THR_INIT  = 8'd128,
   parameter logic [7:0] THR_FIXED = 8'd128,
   parameter int         CNT_W     = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   y_binarization_if.slave  io,
   output logic [1:0]       div_state
);
   logic [7:0] thr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io.bin_vsync <= 1'b0;
         io.bin_hsync <= 1'b0;
         io.bin_de    <= 1'b0;
         io.bin_bit   <= 1'b0;
      end else begin
         io.bin_vsync <= io.ycbcr_vsync;
         io.bin_hsync <= io.ycbcr_hsync;
         io.bin_de    <= io.ycbcr_de;
         io.bin_bit   <= io.ycbcr_de & (io.img_y > thr_q);
      end
   end

   assign io.bin_rgb565 = {16{io.bin_bit}};
   assign io.thr_out    = thr_q;

`ifdef BIN_ADAPTIVE_EN
   localparam int SUM_W = CNT_W + 8;
   localparam int BC_W  = $clog2(SUM_W);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_UPDATE = 2'd2} state_t;
   state_t state, state_nx;

   logic [SUM_W-1:0] sum, quo, sum_close;
   logic [CNT_W-1:0] cnt, dvs, rem, cnt_close;
   logic [CNT_W:0]   rem_sh, rem_sub;
   logic [BC_W-1:0]  bit_cnt;
   logic             edge_e, fit;
   logic             unused_params;

   assign unused_params = ^THR_FIXED;
   // bin_vsync doubles as the registered vsync copy for edge detection.
   assign edge_e    = io.ycbcr_vsync & ~io.bin_vsync;
   assign sum_close = sum + (io.ycbcr_de ? {{(SUM_W-8){1'b0}}, io.img_y} : {SUM_W{1'b0}});
   assign cnt_close = (io.ycbcr_de && cnt != {CNT_W{1'b1}}) ? cnt + {{(CNT_W-1){1'b0}}, 1'b1} : cnt;
   assign rem_sh    = {rem, quo[SUM_W-1]};
   assign rem_sub   = rem_sh - {1'b0, dvs};
   assign fit       = rem_sh >= {1'b0, dvs};
   assign div_state = state;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   state_nx = S_IDLE;
         S_DIV:    if (bit_cnt == '0) state_nx = S_UPDATE;
         S_UPDATE: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      // A new frame edge always wins, aborting any division still in flight.
      if (edge_e) state_nx = (cnt_close != '0) ? S_DIV : S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         sum     <= '0;
         cnt     <= '0;
         dvs     <= '0;
         rem     <= '0;
         quo     <= '0;
         bit_cnt <= '0;
         thr_q   <= THR_INIT;
      end else begin
         state <= state_nx;
         if (edge_e) begin
            sum     <= '0;
            cnt     <= '0;
            dvs     <= cnt_close;
            rem     <= '0;
            quo     <= sum_close;
            bit_cnt <= BC_W'(SUM_W - 1);
         end else begin
            if (io.ycbcr_de) begin
               sum <= sum_close;
               cnt <= cnt_close;
            end
            if (state == S_DIV) begin
               rem     <= fit ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
               quo     <= {quo[SUM_W-2:0], fit};
               bit_cnt <= bit_cnt - 1'b1;
            end
            if (state == S_UPDATE)
               thr_q <= (|quo[SUM_W-1:8]) ? 8'hFF : quo[7:0];
         end
      end
   end
`else
   logic unused_params;

   assign unused_params = ^{THR_INIT, CNT_W};
   assign thr_q         = THR_FIXED;
   assign div_state     = 2'd0;
`endif
endmodule

// File: tb/tb_y_binarization.sv
// Directed bench for y_binarization: vector table for the pixel path, hand sequences for frame-level behaviour.
module tb_y_binarization;
   localparam logic [7:0] THR_FIXED_TB = 8'd50;
`ifdef BIN_ADAPTIVE_EN
   localparam logic [7:0] THR0 = 8'd128;
`else
   localparam logic [7:0] THR0 = THR_FIXED_TB;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] div_state;
   int         checks = 0;
   int         failures = 0;

   logic        prev_v = 1'b0;
   logic [31:0] m_sum = 0;
   logic [31:0] m_cnt = 0;
   logic [7:0]  exp_q[$];

   typedef struct {
      logic       h;
      logic       de;
      logic [7:0] y;
      logic       exp_bit;
   } vec_t;
   vec_t vecs[8];

   y_binarization_if io ();

   y_binarization #(
      .THR_INIT (8'd128),
      .THR_FIXED(THR_FIXED_TB),
      .CNT_W    (21)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io       (io),
      .div_state(div_state)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one beat; the reference mean model pushes its expectation at each rising vsync.
   task automatic drive(input logic v, input logic h, input logic de, input logic [7:0] y);
      io.ycbcr_vsync = v;
      io.ycbcr_hsync = h;
      io.ycbcr_de    = de;
      io.img_y       = y;
      if (v && !prev_v) begin
         if (m_cnt + 32'(de) != 0)
            exp_q.push_back(8'((m_sum + (de ? 32'(y) : 32'd0)) / (m_cnt + 32'(de))));
         m_sum = 0;
         m_cnt = 0;
      end else if (de) begin
         m_sum = m_sum + 32'(y);
         m_cnt = m_cnt + 1;
      end
      prev_v = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic v, input int n);
      for (int i = 0; i < n; i++) drive(v, 1'b0, 1'b0, 8'd0);
   endtask

   initial begin
      io.ycbcr_vsync = 1'b0;
      io.ycbcr_hsync = 1'b0;
      io.ycbcr_de    = 1'b0;
      io.img_y       = 8'd0;

      vecs[0] = '{h: 1'b0, de: 1'b1, y: THR0,              exp_bit: 1'b0};
      vecs[1] = '{h: 1'b1, de: 1'b1, y: 8'(THR0 + 8'd1),   exp_bit: 1'b1};
      vecs[2] = '{h: 1'b1, de: 1'b1, y: 8'd0,              exp_bit: 1'b0};
      vecs[3] = '{h: 1'b0, de: 1'b1, y: 8'd255,            exp_bit: 1'b1};
      vecs[4] = '{h: 1'b0, de: 1'b0, y: 8'd255,            exp_bit: 1'b0};
      vecs[5] = '{h: 1'b1, de: 1'b1, y: 8'(THR0 - 8'd1),   exp_bit: 1'b0};
      vecs[6] = '{h: 1'b0, de: 1'b1, y: 8'(THR0 + 8'd2),   exp_bit: 1'b1};
      vecs[7] = '{h: 1'b0, de: 1'b0, y: 8'd0,              exp_bit: 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_bin_bit", 32'(io.bin_bit), 32'd0);
      check("rst_rgb", 32'(io.bin_rgb565), 32'd0);
      check("rst_de", 32'(io.bin_de), 32'd0);
      check("rst_vsync", 32'(io.bin_vsync), 32'd0);
      check("rst_hsync", 32'(io.bin_hsync), 32'd0);
      check("rst_thr", 32'(io.thr_out), 32'(THR0));
      check("rst_state", 32'(div_state), 32'd0);
      rst_n = 1'b1;

      // Pixel path vectors against the reset threshold
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, vecs[i].h, vecs[i].de, vecs[i].y);
         check($sformatf("vec%0d_bit", i), 32'(io.bin_bit), 32'(vecs[i].exp_bit));
         check($sformatf("vec%0d_rgb", i), 32'(io.bin_rgb565), vecs[i].exp_bit ? 32'hFFFF : 32'h0);
         check($sformatf("vec%0d_de", i), 32'(io.bin_de), 32'(vecs[i].de));
         check($sformatf("vec%0d_hs", i), 32'(io.bin_hsync), 32'(vecs[i].h));
         check($sformatf("vec%0d_thr", i), 32'(io.thr_out), 32'(THR0));
      end

`ifdef BIN_ADAPTIVE_EN
      // Close the table's frame; its mean comes from the reference model.
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      check("flush_vsync", 32'(io.bin_vsync), 32'd1);
      check("flush_state", 32'(div_state), 32'd1);
      idle(1'b1, 29);
      check("flush_e29", 32'(io.thr_out), 32'(THR0));
      idle(1'b1, 1);
      check("flush_e30", 32'(io.thr_out), 32'(exp_q.pop_front()));
      exp_q.delete();

      // Mean update: 8 pixels of 100
      idle(1'b0, 2);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 8'd100);
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      check("mean_state", 32'(div_state), 32'd1);
      idle(1'b1, 29);
      check("mean_e29", 32'(io.thr_out), 32'd128);
      idle(1'b1, 1);
      check("mean_e30", 32'(io.thr_out), 32'd100);
      idle(1'b1, 1);
      check("mean_idle", 32'(div_state), 32'd0);

      // Strict greater-than against the new threshold
      idle(1'b0, 2);
      drive(1'b0, 1'b0, 1'b1, 8'd101);
      check("y101_bit", 32'(io.bin_bit), 32'd1);
      drive(1'b0, 1'b0, 1'b1, 8'd100);
      check("y100_bit", 32'(io.bin_bit), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      idle(1'b1, 30);
      check("mean2_e30", 32'(io.thr_out), 32'd100);

      // Truncating mean; the pixel on the edge closes the old frame
      idle(1'b0, 2);
      drive(1'b0, 1'b0, 1'b1, 8'd10);
      check("y10_bit", 32'(io.bin_bit), 32'd0);
      drive(1'b0, 1'b0, 1'b1, 8'd11);
      drive(1'b0, 1'b0, 1'b1, 8'd12);
      drive(1'b1, 1'b0, 1'b1, 8'd14);
      idle(1'b1, 29);
      check("trunc_e29", 32'(io.thr_out), 32'd100);
      idle(1'b1, 1);
      check("trunc_e30", 32'(io.thr_out), 32'd11);

      // Empty frame leaves the threshold alone
      idle(1'b0, 3);
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      check("empty_state", 32'(div_state), 32'd0);
      idle(1'b1, 35);
      check("empty_thr", 32'(io.thr_out), 32'd11);

      // Abort: second edge 10 cycles after the first
      idle(1'b0, 2);
      drive(1'b0, 1'b0, 1'b1, 8'd50);
      drive(1'b0, 1'b0, 1'b1, 8'd50);
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      drive(1'b0, 1'b0, 1'b0, 8'd0);
      drive(1'b0, 1'b0, 1'b1, 8'd200);
      drive(1'b0, 1'b0, 1'b1, 8'd200);
      idle(1'b0, 6);
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      check("abort_state", 32'(div_state), 32'd1);
      idle(1'b1, 20);
      check("abort_e30", 32'(io.thr_out), 32'd11);
      idle(1'b1, 9);
      check("abort_e39", 32'(io.thr_out), 32'd11);
      idle(1'b1, 1);
      check("abort_e40", 32'(io.thr_out), 32'd200);

      // Reset in the middle of a division
      idle(1'b0, 2);
      drive(1'b0, 1'b0, 1'b1, 8'd30);
      drive(1'b0, 1'b0, 1'b1, 8'd30);
      drive(1'b1, 1'b0, 1'b0, 8'd0);
      idle(1'b1, 10);
      rst_n = 1'b0;
      #1;
      check("midrst_thr", 32'(io.thr_out), 32'd128);
      check("midrst_state", 32'(div_state), 32'd0);
      check("midrst_vsync", 32'(io.bin_vsync), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1'b1, 25);
      check("midrst_after", 32'(io.thr_out), 32'd128);
`else
      // Fixed threshold across several frames
      for (int f = 0; f < 3; f++) begin
         idle(1'b0, 2);
         drive(1'b0, 1'b0, 1'b1, 8'd51);
         check($sformatf("fix%0d_y51", f), 32'(io.bin_bit), 32'd1);
         drive(1'b0, 1'b0, 1'b1, 8'd50);
         check($sformatf("fix%0d_y50", f), 32'(io.bin_bit), 32'd0);
         drive(1'b1, 1'b0, 1'b0, 8'd0);
         idle(1'b1, 35);
         check($sformatf("fix%0d_thr", f), 32'(io.thr_out), 32'd50);
         check($sformatf("fix%0d_state", f), 32'(div_state), 32'd0);
      end
      rst_n = 1'b0;
      #1;
      check("fix_rst_thr", 32'(io.thr_out), 32'd50);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/y_binarization.md
# y_binarization

Converts the 8-bit luma stream from the RGB-to-YCbCr stage into a 1-bit binary image, with a threshold that adapts each frame to the mean luma of the previous frame. It sits directly downstream of the YCbCr converter and upstream of the display/frame-buffer writer. A per-frame accumulator collects luma over active pixels. A sequential restoring divider runs during vertical blanking to compute the mean for the next frame.

## Interface
- THR_INIT, 8'd128, threshold after reset and until the first valid division.
- THR_FIXED, 8'd128, constant threshold used when adaptation is compiled out.
- CNT_W, 21, pixel counter width (up to 2^21-1 pixels per frame).
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous, active-low reset.
- ycbcr_vsync  input  1  frame sync from the YCbCr stage, active high.
- ycbcr_hsync  input  1  line sync, passed through.
- ycbcr_de  input  1  active-pixel qualifier.
- img_y  input  8  luma; valid only when ycbcr_de=1.
- bin_vsync  output  1  ycbcr_vsync delayed 1 cycle.
- bin_hsync  output  1  ycbcr_hsync delayed 1 cycle.
- bin_de  output  1  ycbcr_de delayed 1 cycle.
- bin_bit  output  1  1 when the pixel is above threshold; 0 when bin_de=0.
- bin_rgb565  output  16  16'hFFFF if bin_bit else 16'h0000.
- thr_out  output  8  threshold currently applied.

## Operation
- Pixel path:
  - bin_bit <= ycbcr_de & (img_y > thr_q), using strict greater-than.
  - Syncs are registered alongside bin_bit.
  - The threshold is compared against img_y only; img_cb and img_cr are not used.
- Statistics:
  - On ycbcr_de=1: sum <= sum + img_y and cnt <= cnt + 1.
  - sum is CNT_W+8 = 29 bits; it cannot overflow within CNT_W pixel capacity.
  - cnt saturates at all-ones. The sum keeps accumulating, so the mean becomes approximate; this is acceptable.
- Frame edge E is a rising ycbcr_vsync, detected against a registered copy (vsync_q=0, ycbcr_vsync=1). At E:
  - The dividend is latched from sum plus the current pixel if de=1.
  - The divisor is latched from cnt plus that pixel.
  - The accumulators restart at 0.
  - A pixel with de=1 at edge E counts toward the closing frame.
- Divider FSM:
  - IDLE: wait for E. If the latched divisor = 0, stay in IDLE and leave thr_q unchanged. Otherwise load the remainder/quotient and set bit_cnt = 28 → DIV.
  - DIV: one restoring step per cycle (shift, trial-subtract the divisor, set the quotient bit). bit_cnt decrements; when it reaches 0 → UPDATE.
  - UPDATE: thr_q <= quotient[7:0], saturated to 8'hFF if the upper quotient bits are non-zero (cannot occur with legal data) → IDLE.
  - An edge E in DIV or UPDATE aborts the in-flight division and reloads with the new frame's values (back-to-back frames).
- Reset: all registers are cleared. thr_q = THR_INIT, FSM = IDLE, sum = cnt = 0.

## Timing
- Pixel latency: 1 cycle, with syncs and data aligned.
- All outputs are 0 after reset, except thr_out = THR_INIT.
- Threshold update: thr_out changes at clock edge E+30 (29 DIV cycles, then UPDATE). It is stable for the whole next active region, provided vertical front porch plus sync is ≥ 31 cycles.
- A threshold computed from frame N applies to frame N+1.
- A pixel whose comparison straddles the update edge uses the old thr_q (registered compare).
- Reset asserted mid-division abandons the division; thr_out returns to THR_INIT.

## Configuration
- BIN_ADAPTIVE_EN defined:
  - The accumulators, divider FSM and adaptive thr_q are compiled in, as described above.
- BIN_ADAPTIVE_EN undefined:
  - The accumulators and divider are not built.
  - thr_q is the constant THR_FIXED, and thr_out = THR_FIXED at all times, including reset.
  - The pixel path and its latency are unchanged.

## Test plan
- Reset threshold: after reset, thr_out=128; de=1 with img_y=128 → bin_bit=0; img_y=129 → bin_bit=1 one cycle later with bin_rgb565=16'hFFFF.
- Mean update: frame of 8 pixels all Y=100, then vsync rise at E → thr_out=100 exactly at E+30; next frame Y=101 → 1, Y=100 → 0.
- Non-integer mean: pixels 10, 11, 12, 14 (sum 47, cnt 4) → thr_out=11 (truncation).
- Empty frame: two vsync rises with no de between → thr_out unchanged, FSM returns to IDLE in 1 cycle.
- Abort: second vsync rise 10 cycles after E, with 2 pixels Y=200 between → first division discarded; thr_out=200 at E+10+30.
- Macro off: BIN_ADAPTIVE_EN undefined, THR_FIXED=50 → thr_out=50 always; Y=51 → 1 and Y=50 → 0 across multiple frames.
